// File: rtl/alu_mp_pkg.sv
// Shared types for the word-serial multi-precision add/subtract engine.
package alu_mp_pkg;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    ADC = 2'b10,
    SBC = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  function automatic logic is_sub(alu_op_t op);
    return (op == SUB) || (op == SBC);
  endfunction

  // Subtract runs as A + ~B + c, so a borrow-in of 1 seeds a carry of 0.
  function automatic logic seed_carry(alu_op_t op, logic c_in);
    logic c0;
    unique case (op)
      ADD:     c0 = 1'b0;
      SUB:     c0 = 1'b1;
      ADC:     c0 = c_in;
      SBC:     c0 = ~c_in;
      default: c0 = 1'b0;
    endcase
    return c0;
  endfunction

endpackage

// File: rtl/alu_mp_seq_if.sv
// Request/result bundle of the multi-precision add/subtract engine.
interface alu_mp_seq_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned WORDS = 4
);
  localparam int unsigned TW = WIDTH * WORDS;

  logic          alu_start_in;
  logic [1:0]    alu_op_in;
  logic          alu_C_in;
  logic [TW-1:0] alu_A_in;
  logic [TW-1:0] alu_B_in;
  logic          alu_busy_out;
  logic          alu_done_out;
  logic [TW-1:0] alu_out;
  logic          alu_Z_out;
  logic          alu_N_out;
  logic          alu_C_out;
  logic          alu_V_out;

  modport master (
    output alu_start_in, alu_op_in, alu_C_in, alu_A_in, alu_B_in,
    input  alu_busy_out, alu_done_out, alu_out, alu_Z_out, alu_N_out, alu_C_out, alu_V_out
  );

  modport slave (
    input  alu_start_in, alu_op_in, alu_C_in, alu_A_in, alu_B_in,
    output alu_busy_out, alu_done_out, alu_out, alu_Z_out, alu_N_out, alu_C_out, alu_V_out
  );

endinterface

// File: rtl/alu_slice.sv
// One WIDTH-bit slice adder with optional B inversion for subtract.
module alu_slice #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c,
  input  logic             i_inv_b,
  output logic [WIDTH-1:0] o_sum,
  output logic [WIDTH-1:0] o_b_eff,
  output logic             o_c
);

  assign o_b_eff      = i_inv_b ? ~i_b : i_b;
  assign {o_c, o_sum} = {1'b0, i_a} + {1'b0, o_b_eff} + {{WIDTH{1'b0}}, i_c};

endmodule

// File: rtl/alu_mp_seq.sv
// Word-serial multi-precision add/subtract: one slice per clock, LSW first,
// with results and flags updated only on the last-slice edge.
module alu_mp_seq
  import alu_mp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned WORDS = 4
) (
  input logic         clk,
  input logic         reset,
  alu_mp_seq_if.slave bus
);

  localparam int unsigned TW = WIDTH * WORDS;
  localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  alu_state_t      r_state, w_state_next;
  logic [IW-1:0]   r_idx;
  logic [TW-1:0]   r_a, r_b, r_acc, r_out;
  logic            r_sub, r_c;
  logic            r_z, r_n, r_cf, r_v;

  alu_op_t         w_op;
  logic            w_accept, w_last;
  logic [WIDTH-1:0] w_a_sl, w_b_sl, w_sum, w_b_eff;
  logic            w_cout;
  logic [TW-1:0]   w_res;

  assign w_op     = alu_op_t'(bus.alu_op_in);
  assign w_accept = ((r_state == IDLE) || (r_state == DONE)) && bus.alu_start_in;
  assign w_last   = (r_idx == IW'(WORDS - 1));
  assign w_a_sl   = r_a[r_idx * WIDTH +: WIDTH];
  assign w_b_sl   = r_b[r_idx * WIDTH +: WIDTH];

  alu_slice #(
    .WIDTH (WIDTH)
  ) u_slice (
    .i_a     (w_a_sl),
    .i_b     (w_b_sl),
    .i_c     (r_c),
    .i_inv_b (r_sub),
    .o_sum   (w_sum),
    .o_b_eff (w_b_eff),
    .o_c     (w_cout)
  );

  // Accumulator with the in-flight slice merged, used on the last edge.
  always_comb begin
    w_res = r_acc;
    w_res[r_idx * WIDTH +: WIDTH] = w_sum;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.alu_start_in) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    w_state_next = bus.alu_start_in ? RUN : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_out <= '0;
      r_sub <= 1'b0;
      r_c   <= 1'b0;
      r_z   <= 1'b0;
      r_n   <= 1'b0;
      r_cf  <= 1'b0;
      r_v   <= 1'b0;
    end else if (w_accept) begin
      r_a   <= bus.alu_A_in;
      r_b   <= bus.alu_B_in;
      r_sub <= is_sub(w_op);
      r_c   <= seed_carry(w_op, bus.alu_C_in);
      r_idx <= '0;
    end else if (r_state == RUN) begin
      r_acc[r_idx * WIDTH +: WIDTH] <= w_sum;
      r_c                           <= w_cout;
      if (w_last) begin
        r_idx <= '0;
        r_out <= w_res;
        r_z   <= (w_res == '0);
        r_n   <= w_sum[WIDTH-1];
        // Borrow is the inverted carry when subtracting.
        r_cf  <= r_sub ^ w_cout;
        r_v   <= (w_a_sl[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                 (w_sum[WIDTH-1] != w_a_sl[WIDTH-1]);
      end else begin
        r_idx <= r_idx + IW'(1);
      end
    end
  end

  assign bus.alu_busy_out = (r_state == RUN);
  assign bus.alu_done_out = (r_state == DONE);
  assign bus.alu_out      = r_out;
  assign bus.alu_Z_out    = r_z;
  assign bus.alu_N_out    = r_n;
  assign bus.alu_C_out    = r_cf;
  assign bus.alu_V_out    = r_v;

endmodule

// File: tb/tb_alu_mp_seq.sv
// Directed bench for alu_mp_seq (8-bit slices, 4 words) with a cycle-level model.
module tb_alu_mp_seq;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned WORDS = 4;
  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpAdc = 2'b10;
  localparam logic [1:0] OpSbc = 2'b11;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
  } res_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic chk_en = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  alu_mp_seq_if #(.WIDTH(WIDTH), .WORDS(WORDS)) bus ();

  alu_mp_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-operand arithmetic: the result must match TW-bit add/subtract.
  function automatic res_t model_op(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input logic cin);
    res_t        x;
    logic        bin;
    logic [32:0] t;
    bin = op[1] ? cin : 1'b0;
    if (op[0]) begin
      x.r = a - b - {31'b0, bin};
      x.c = ({1'b0, a} < ({1'b0, b} + {32'b0, bin}));
      x.v = (a[31] != b[31]) && (x.r[31] != a[31]);
    end else begin
      t   = {1'b0, a} + {1'b0, b} + {32'b0, bin};
      x.r = t[31:0];
      x.c = t[32];
      x.v = (a[31] == b[31]) && (x.r[31] != a[31]);
    end
    x.z = (x.r == 32'h0);
    x.n = x.r[31];
    return x;
  endfunction

  // Model: an accepted op completes WORDS edges later; results visible from then on.
  int   m_left = 0;
  logic m_done = 1'b0;
  res_t m_pend = '0;
  res_t e_res = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left <= 0;
      m_done <= 1'b0;
      e_res  <= '0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        e_res  <= m_pend;
        m_done <= 1'b1;
      end
    end else begin
      m_done <= 1'b0;
      if (bus.alu_start_in) begin
        m_pend <= model_op(bus.alu_op_in, bus.alu_A_in, bus.alu_B_in, bus.alu_C_in);
        m_left <= WORDS;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_out", bus.alu_out, e_res.r);
      chk("cyc_flags", {28'b0, bus.alu_Z_out, bus.alu_N_out, bus.alu_C_out, bus.alu_V_out},
          {28'b0, e_res.z, e_res.n, e_res.c, e_res.v});
      chk("cyc_busy", {31'b0, bus.alu_busy_out}, {31'b0, (m_left > 0)});
      chk("cyc_done", {31'b0, bus.alu_done_out}, {31'b0, m_done});
    end
  end

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cin);
    bus.alu_start_in = 1'b1;
    bus.alu_op_in    = op;
    bus.alu_A_in     = a;
    bus.alu_B_in     = b;
    bus.alu_C_in     = cin;
  endtask

  // Counts negedges from now until done is seen (bounded).
  task automatic wait_done(output int n, output int nb);
    n  = 0;
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n++;
      if (bus.alu_busy_out) nb++;
      if (bus.alu_done_out) break;
    end
    chk("done_seen", {31'b0, bus.alu_done_out}, 32'd1);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, output int n, output int nb);
    @(posedge clk);
    #1 drive(op, a, b, cin);
    @(posedge clk);
    #1 bus.alu_start_in = 1'b0;
    wait_done(n, nb);
  endtask

  task automatic chk_res(input string name, input logic [31:0] exp_out,
                         input logic [3:0] exp_zncv);
    chk({name, "_out"}, bus.alu_out, exp_out);
    chk({name, "_zncv"}, {28'b0, bus.alu_Z_out, bus.alu_N_out, bus.alu_C_out, bus.alu_V_out},
        {28'b0, exp_zncv});
  endtask

  int n_lat, n_busy;

  initial begin
    bus.alu_start_in = 1'b0;
    bus.alu_op_in    = 2'b00;
    bus.alu_A_in     = '0;
    bus.alu_B_in     = '0;
    bus.alu_C_in     = 1'b0;
    #1 reset = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk_res("rst", 32'h0, 4'b0000);
    chk("rst_busy", {31'b0, bus.alu_busy_out}, 32'd0);
    chk("rst_done", {31'b0, bus.alu_done_out}, 32'd0);
    reset = 1'b0;

    run_op(OpAdd, 32'h0000FFFF, 32'h00000001, 1'b0, n_lat, n_busy);
    chk("t1_lat", n_lat, WORDS + 1);
    chk("t1_busy", n_busy, WORDS);
    chk_res("t1", 32'h00010000, 4'b0000);

    run_op(OpSub, 32'h00000000, 32'h00000001, 1'b0, n_lat, n_busy);
    chk_res("t2", 32'hFFFFFFFF, 4'b0110);

    run_op(OpAdd, 32'h7FFFFFFF, 32'h00000001, 1'b0, n_lat, n_busy);
    chk_res("t3a", 32'h80000000, 4'b0101);
    run_op(OpSub, 32'h80000000, 32'h00000001, 1'b0, n_lat, n_busy);
    chk_res("t3b", 32'h7FFFFFFF, 4'b0001);

    run_op(OpAdc, 32'hFFFFFFFF, 32'h00000000, 1'b1, n_lat, n_busy);
    chk_res("t4a", 32'h00000000, 4'b1010);
    run_op(OpSbc, 32'h00000005, 32'h00000005, 1'b1, n_lat, n_busy);
    chk_res("t4b", 32'hFFFFFFFF, 4'b0110);

    // start pulsed mid-RUN must be ignored
    @(posedge clk);
    #1 drive(OpAdd, 32'h11111111, 32'h22222222, 1'b0);
    @(posedge clk);
    #1 bus.alu_start_in = 1'b0;
    @(posedge clk);
    #1 drive(OpSub, 32'hAAAAAAAA, 32'h00000001, 1'b0);
    @(posedge clk);
    #1 bus.alu_start_in = 1'b0;
    wait_done(n_lat, n_busy);
    chk_res("t5a", 32'h33333333, 4'b0000);

    // start held in the DONE cycle chains straight into the next op
    drive(OpAdd, 32'h10000000, 32'h01000000, 1'b0);
    @(posedge clk);
    #1 bus.alu_start_in = 1'b0;
    @(negedge clk);
    chk("t5_hold", bus.alu_out, 32'h33333333);
    wait_done(n_lat, n_busy);
    chk("t5_lat", n_lat, WORDS);
    chk_res("t5b", 32'h11000000, 4'b0000);

    // reset at idx 2 clears everything asynchronously
    @(posedge clk);
    #1 drive(OpAdd, 32'h0F0F0F0F, 32'h01010101, 1'b0);
    @(posedge clk);
    #1 bus.alu_start_in = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    bus.alu_start_in = 1'b1;
    #1 chk_res("t6_rst", 32'h0, 4'b0000);
    chk("t6_busy", {31'b0, bus.alu_busy_out}, 32'd0);
    chk("t6_done", {31'b0, bus.alu_done_out}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("t6_busy2", {31'b0, bus.alu_busy_out}, 32'd0);
    bus.alu_start_in = 1'b0;
    reset = 1'b0;
    run_op(OpAdd, 32'h00000001, 32'h00000001, 1'b0, n_lat, n_busy);
    chk("t6_lat", n_lat, WORDS + 1);
    chk_res("t6", 32'h00000002, 4'b0000);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
